imem_fetch_sequencer: RTL and testbench

- Fetch controller that sequences the read-only instruction memory.
- Owns the PC, drives the 64-bit instruction address, waits a fixed read latency, and captures the 32-bit word.
- Presents the word to decode over a valid/ready handshake.
- Accepts branch redirects from the execute stage and start/stop control from the testbench or top level.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/imem_fetch_sequencer_lat_counter.sv | 42 ++++
 rtl/imem_fetch_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_imem_fetch_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and widths for the instruction fetch path.
//   fetch_state_t   : sequencer state encoding (IDLE / WAIT / HOLD)
//   INST_W, ADDR_W  : instruction word and address widths
//   LAT_W           : latency counter width, large enough for read latencies up to 15
//   PC_STEP_DEFAULT : default sequential PC increment in bytes
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int INST_W          = 32;
    localparam int ADDR_W          = 64;
    localparam int LAT_W           = $clog2(16);
    localparam int PC_STEP_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/imem_fetch_sequencer_lat_counter.sv
// ---------------------------------------------------------------------------
// lat_counter
// Loadable down-counter used to time a fixed memory read latency.
// The same block is meant to be shared with the data memory controller.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (count returns to 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; the count holds at zero
//   count    : current count
//   zero     : count == 0
// ---------------------------------------------------------------------------
module lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - ONE;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/imem_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// imem_fetch_sequencer
// Fetch controller for the read-only instruction memory. Owns the PC, drives
// the instruction address, waits RD_LAT cycles, captures the 32-bit word and
// presents it to decode over a valid/ready handshake. Execute-stage branch
// redirects squash any word in flight and restart fetching at the target.
//
// Ports:
//   CLK            : clock, rising edge
//   Reset_L        : asynchronous active-low reset
//   start          : pulse, load start_pc and begin fetching (IDLE only)
//   start_pc       : start address
//   stop           : level, finish the current word then return to IDLE
//   redirect_valid : branch taken, squash and refetch from redirect_pc
//   redirect_pc    : branch target
//   imem_addr      : instruction memory address (registered, equals the PC)
//   imem_data      : word returned by instruction memory
//   inst_valid     : inst_data / inst_pc valid
//   inst_ready     : decode accepts the presented word
//   inst_data      : captured instruction
//   inst_pc        : address of inst_data
//   busy           : sequencer is not IDLE
//
// Optional build macro FETCH_PERF_CNT_EN adds two saturating counters:
//   fetch_count    : words accepted by decode (inst_valid & inst_ready)
//   squash_count   : redirects taken while in WAIT or HOLD
// ---------------------------------------------------------------------------
module imem_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                RD_LAT   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              stop,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       squash_count
`endif
);

    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
    localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RD_LAT);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(1);

    // Reject unusable latencies when the design is elaborated.
    generate
        if ((RD_LAT < 1) || (RD_LAT > 15)) begin : g_bad_rd_lat
            $error("imem_fetch_sequencer: RD_LAT=%0d is outside 1..15", RD_LAT);
        end
    endgenerate

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic              inst_valid_reg;
    logic [INST_W-1:0] inst_data_reg;
    logic [ADDR_W-1:0] inst_pc_reg;
    logic              busy_reg;

    logic              lat_load;
    logic              lat_dec;
    logic [LAT_W-1:0]  lat_count;
    logic              lat_zero;

    // Every path into WAIT restarts the latency count: start from IDLE, a
    // redirect in WAIT/HOLD, or a handshake in HOLD that continues fetching.
    always_comb begin
        lat_load = 1'b0;
        lat_dec  = 1'b0;
        case (state_reg)
            IDLE: begin
                lat_load = start;
            end
            WAIT: begin
                lat_load = redirect_valid;
                lat_dec  = !lat_zero;
            end
            HOLD: begin
                lat_load = redirect_valid || (inst_ready && !stop);
            end
            default: begin
                lat_load = 1'b0;
            end
        endcase
    end

    lat_counter #(
        .W (LAT_W)
    ) u_lat_counter (
        .clk      (CLK),
        .rst_n    (Reset_L),
        .load     (lat_load),
        .load_val (LAT_LOAD),
        .dec      (lat_dec),
        .count    (lat_count),
        .zero     (lat_zero)
    );

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            inst_valid_reg <= 1'b0;
            inst_data_reg  <= '0;
            inst_pc_reg    <= '0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Redirects are meaningless with nothing in flight.
                    if (start) begin
                        pc_reg    <= start_pc;
                        state_reg <= WAIT;
                        busy_reg  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        // The read in flight is abandoned; the counter reloads.
                        pc_reg <= redirect_pc;
                    end else if (lat_count == LAT_LAST) begin
                        // Last latency cycle: memory output is valid for pc_reg.
                        inst_data_reg  <= imem_data;
                        inst_pc_reg    <= pc_reg;
                        inst_valid_reg <= 1'b1;
                        state_reg      <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        // Redirect wins over a simultaneous handshake.
                        pc_reg         <= redirect_pc;
                        inst_valid_reg <= 1'b0;
                        state_reg      <= WAIT;
                    end else if (inst_ready) begin
                        inst_valid_reg <= 1'b0;
                        pc_reg         <= pc_reg + STEP;
                        if (stop) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    inst_valid_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr  = pc_reg;
    assign inst_valid = inst_valid_reg;
    assign inst_data  = inst_data_reg;
    assign inst_pc    = inst_pc_reg;
    assign busy       = busy_reg;

`ifdef FETCH_PERF_CNT_EN
    logic        handshake;
    logic        redirect_take;
    logic [31:0] fetch_count_reg;
    logic [31:0] squash_count_reg;

    // A redirect coinciding with a handshake still counts the held word as
    // consumed, so both counters can step in the same cycle.
    assign handshake     = inst_valid_reg && inst_ready;
    assign redirect_take = redirect_valid && ((state_reg == WAIT) || (state_reg == HOLD));

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            fetch_count_reg  <= '0;
            squash_count_reg <= '0;
        end else begin
            if (handshake && (fetch_count_reg != 32'hFFFF_FFFF)) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
            if (redirect_take && (squash_count_reg != 32'hFFFF_FFFF)) begin
                squash_count_reg <= squash_count_reg + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_count_reg;
    assign squash_count = squash_count_reg;
`endif

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_sequencer
// Directed bench for imem_fetch_sequencer with RD_LAT=2 and a combinational
// stub instruction memory. Inputs change 1 time unit after the rising edge
// and outputs are sampled there as well, well away from the next edge.
// Build with +define+FETCH_PERF_CNT_EN to also check the performance counters.
// ---------------------------------------------------------------------------
module tb_imem_fetch_sequencer;

    logic        CLK;
    logic        Reset_L;
    logic        start;
    logic [63:0] start_pc;
    logic        stop;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] squash_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    imem_fetch_sequencer #(
        .RD_LAT   (2),
        .RESET_PC (64'h0),
        .PC_STEP  (4)
    ) dut (
        .CLK            (CLK),
        .Reset_L        (Reset_L),
        .start          (start),
        .start_pc       (start_pc),
        .stop           (stop),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .busy           (busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .squash_count   (squash_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stub memory: a real opcode at address 0, a tagged address elsewhere.
    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        if (addr == 64'h0) return 32'hF840_03E9;
        return {16'hC0DE, addr[15:0]};
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Bounded wait for a presented word; an expired bound fails the check.
    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        while (!inst_valid && (n < max_cycles)) begin
            tick();
            n++;
        end
        check_eq("wait_valid", {63'b0, inst_valid}, 64'd1);
    endtask

    task automatic check_word(input string tag, input logic [63:0] pc);
        check_eq({tag, "_valid"}, {63'b0, inst_valid}, 64'd1);
        check_eq({tag, "_pc"}, inst_pc, pc);
        check_eq({tag, "_data"}, {32'b0, inst_data}, {32'b0, mem_word(pc)});
        $display("[%0t] %s word pc=%h data=%h", $time, tag, inst_pc, inst_data);
    endtask

    initial begin
        logic [63:0] exp_pc;

        Reset_L        = 1'b0;
        start          = 1'b0;
        start_pc       = 64'h0;
        stop           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        inst_ready     = 1'b0;

        // Reset values
        tick(); tick();
        check_eq("rst_valid", {63'b0, inst_valid}, 64'd0);
        check_eq("rst_busy", {63'b0, busy}, 64'd0);
        check_eq("rst_addr", imem_addr, 64'h0);
        check_eq("rst_data", {32'b0, inst_data}, 64'h0);
        check_eq("rst_pc", inst_pc, 64'h0);
        $display("[%0t] reset released", $time);
        Reset_L = 1'b1;
        tick();

        // First fetch from 0 and throughput with ready held high
        start = 1'b1; start_pc = 64'h0; inst_ready = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_busy", {63'b0, busy}, 64'd1);
        check_eq("start_valid", {63'b0, inst_valid}, 64'd0);
        tick();
        check_eq("lat1_valid", {63'b0, inst_valid}, 64'd0);
        tick();
        check_word("first", 64'h0);
        check_eq("first_opcode", {32'b0, inst_data}, 64'hF840_03E9);
        tick();
        check_eq("hs_valid", {63'b0, inst_valid}, 64'd0);
        check_eq("hs_addr", imem_addr, 64'h4);
        tick();
        check_eq("lat2_valid", {63'b0, inst_valid}, 64'd0);
        tick();
        check_word("second", 64'h4);

        // Back-pressure: word and address hold steady
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid", {63'b0, inst_valid}, 64'd1);
            check_eq("bp_pc", inst_pc, 64'h4);
            check_eq("bp_addr", imem_addr, 64'h4);
        end
        check_eq("bp_data", {32'b0, inst_data}, {32'b0, mem_word(64'h4)});

        // Handshake with stop returns to IDLE
        stop = 1'b1; inst_ready = 1'b1;
        tick();
        check_eq("stop_valid", {63'b0, inst_valid}, 64'd0);
        check_eq("stop_busy", {63'b0, busy}, 64'd0);

        // stop held from start: exactly one word at 0x2C
        start = 1'b1; start_pc = 64'h2C;
        tick();
        start = 1'b0;
        check_eq("s2c_addr", imem_addr, 64'h2C);
        check_eq("s2c_busy", {63'b0, busy}, 64'd1);
        tick(); tick();
        check_word("s2c", 64'h2C);
        tick();
        check_eq("s2c_done_busy", {63'b0, busy}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("s2c_idle_valid", {63'b0, inst_valid}, 64'd0);
        end
        stop = 1'b0;

        // Redirect during WAIT for 0x28: next word is 0x1C
        inst_ready = 1'b0;
        start = 1'b1; start_pc = 64'h28;
        tick();
        start = 1'b0;
        check_eq("reload_addr", imem_addr, 64'h28);
        redirect_valid = 1'b1; redirect_pc = 64'h1C;
        tick();
        redirect_valid = 1'b0;
        check_eq("rdw_addr", imem_addr, 64'h1C);
        check_eq("rdw_valid", {63'b0, inst_valid}, 64'd0);
        tick();
        check_eq("rdw_lat_valid", {63'b0, inst_valid}, 64'd0);
        tick();
        check_word("rdw", 64'h1C);
        stop = 1'b1; inst_ready = 1'b1;
        tick();
        check_eq("rdw_stop_busy", {63'b0, busy}, 64'd0);
        stop = 1'b0; inst_ready = 1'b0;

        // Redirect and handshake in the same cycle while holding 0x28
        start = 1'b1; start_pc = 64'h28;
        tick();
        start = 1'b0;
        tick(); tick();
        check_word("rdh_hold", 64'h28);
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h1C;
        tick();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        check_eq("rdh_valid", {63'b0, inst_valid}, 64'd0);
        check_eq("rdh_addr", imem_addr, 64'h1C);
        tick(); tick();
        check_word("rdh", 64'h1C);

        // Asynchronous reset in the middle of WAIT
        inst_ready = 1'b1;
        tick();
        check_eq("pre_rst_addr", imem_addr, 64'h20);
        #2;
        Reset_L = 1'b0;
        #1;
        check_eq("arst_valid", {63'b0, inst_valid}, 64'd0);
        check_eq("arst_busy", {63'b0, busy}, 64'd0);
        check_eq("arst_addr", imem_addr, 64'h0);
        check_eq("arst_pc", inst_pc, 64'h0);
        check_eq("arst_data", {32'b0, inst_data}, 64'h0);
        $display("[%0t] async reset applied mid-fetch", $time);
        tick();
        Reset_L = 1'b1;
        tick();
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_rst_fetch", {32'b0, fetch_count}, 64'd0);
        check_eq("perf_rst_squash", {32'b0, squash_count}, 64'd0);
`endif

        // Ten handshakes with two redirects in WAIT
        inst_ready = 1'b1;
        start = 1'b1; start_pc = 64'h0;
        tick();
        start = 1'b0;
        exp_pc = 64'h0;
        for (int i = 0; i < 10; i++) begin
            wait_valid(8);
            check_word("run", exp_pc);
            if (i == 9) stop = 1'b1;
            tick();
            check_eq("run_hs_valid", {63'b0, inst_valid}, 64'd0);
            if (i == 3 || i == 7) begin
                exp_pc = 64'h100 * (i + 1);
                redirect_valid = 1'b1; redirect_pc = exp_pc;
                tick();
                redirect_valid = 1'b0;
                check_eq("run_rd_addr", imem_addr, exp_pc);
            end else begin
                exp_pc = exp_pc + 64'd4;
            end
        end
        stop = 1'b0;
        check_eq("run_end_busy", {63'b0, busy}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_fetch", {32'b0, fetch_count}, 64'd10);
        check_eq("perf_squash", {32'b0, squash_count}, 64'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
